// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit carry-lookahead adder (A+B+Cin) with valid/ready handshakes.
// Define CLA_PIPE_OVF_EN to add the registered signed-overflow output 'ovf'.
module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int BLOCK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             in2,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   out0,
  output logic             out_valid,
  input  logic             out_ready
`ifdef CLA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NBLK = SEG / BLOCK;

  // Two-level lookahead: per-block group P/G, then every group carry as a flat sum of products.
  function automatic logic [SEG:0] cla_carries(input logic [SEG-1:0] a,
                                               input logic [SEG-1:0] b,
                                               input logic           cin);
    logic [SEG-1:0]  p;
    logic [SEG-1:0]  g;
    logic [SEG:0]    cy;
    logic [NBLK-1:0] gp;
    logic [NBLK-1:0] gg;
    logic [NBLK:0]   gc;
    logic            t;
    p = a ^ b;
    g = a & b;
    for (int j = 0; j < NBLK; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        gg[j] = g[j*BLOCK+i] | (p[j*BLOCK+i] & gg[j]);
        gp[j] = gp[j] & p[j*BLOCK+i];
      end
    end
    gc[0] = cin;
    for (int j = 0; j < NBLK; j++) begin
      gc[j+1] = 1'b0;
      t = 1'b1;
      for (int k = j; k >= 0; k--) begin
        gc[j+1] = gc[j+1] | (gg[k] & t);
        t = t & gp[k];
      end
      gc[j+1] = gc[j+1] | (t & cin);
    end
    for (int j = 0; j < NBLK; j++) begin
      cy[j*BLOCK] = gc[j];
      for (int i = 0; i < BLOCK - 1; i++) begin
        cy[j*BLOCK+i+1] = g[j*BLOCK+i] | (p[j*BLOCK+i] & cy[j*BLOCK+i]);
      end
    end
    cy[SEG] = gc[NBLK];
    return cy;
  endfunction

  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - k*SEG;

    logic [REM-1:0]         a_in;
    logic [REM-1:0]         b_in;
    logic                   c_in;
    logic                   v_in;
    logic [SEG:0]           c;
    logic [(k+1)*SEG-1:0]   s_d;
    logic [(k+1)*SEG-1:0]   s_q;
    logic                   co_q;
    logic                   v_q;

    if (k == 0) begin : g_head
      assign a_in = in0;
      assign b_in = in1;
      assign c_in = in2;
      assign v_in = in_valid && in_ready;
      assign s_d  = a_in[SEG-1:0] ^ b_in[SEG-1:0] ^ c[SEG-1:0];
    end else begin : g_body
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign c_in = g_stage[k-1].co_q;
      assign v_in = g_stage[k-1].v_q;
      assign s_d  = {a_in[SEG-1:0] ^ b_in[SEG-1:0] ^ c[SEG-1:0], g_stage[k-1].s_q};
    end

    assign c = cla_carries(a_in[SEG-1:0], b_in[SEG-1:0], c_in);

    // Whole pipeline moves in lockstep so a stalled result never gets overwritten.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q  <= '0;
        co_q <= 1'b0;
        v_q  <= 1'b0;
      end else if (en) begin
        s_q  <= s_d;
        co_q <= c[SEG];
        v_q  <= v_in;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-SEG-1:0] a_q;
      logic [REM-SEG-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[REM-1:SEG];
          b_q <= b_in[REM-1:SEG];
        end
      end
    end

`ifdef CLA_PIPE_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;

      // Carry into the MSB differs from carry out of it exactly on signed overflow.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= c[SEG] ^ c[SEG-1];
        end
      end
    end
`endif
  end

  assign out0      = {g_stage[STAGES-1].co_q, g_stage[STAGES-1].s_q};
  assign out_valid = g_stage[STAGES-1].v_q;
`ifdef CLA_PIPE_OVF_EN
  assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
